// File: rtl/uart_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_sched_pkg
// Brief    : Shared types and constants for the UART transmit scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package uart_sched_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CMD  = 3'd2,
    POLL = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int CTRL_SEND_BIT = 0;
  localparam int CTRL_LEN_LSB  = 4;
  localparam int LEN_W         = 8;
  localparam int DATA_W        = 32;

  // Control word that starts a send of words 0..len.
  function automatic logic [DATA_W-1:0] ctrl_word(input logic [LEN_W-1:0] len);
    logic [DATA_W-1:0] w;
    w                          = '0;
    w[CTRL_SEND_BIT]           = 1'b1;
    w[CTRL_LEN_LSB +: LEN_W]   = len;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_rr_arbiter
// Brief    : Combinational round-robin pick: first request at or after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Walk the requesters cyclically from the pointer and take the first hit.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    cand = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_REQ)) begin
        sum = sum - (IDX_W+1)'(N_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Brief    : Round-robin sharing of the UART register interface: loads the
//            granted requester's words, writes the send command, polls status.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int POLL_GAP = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*LEN_W-1:0]  len_i,
  input  logic [N_REQ*DATA_W-1:0] word_i,
  input  logic [N_REQ-1:0]        word_valid_i,
  output logic [N_REQ-1:0]        word_ready_o,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [N_REQ-1:0]        done_o,
  output logic                    busy_o,
  output logic                    wr_o,
  output logic                    reg_sel_o,
  output logic [DATA_W-1:0]       entrada_o,
  output logic [DATA_W-1:0]       addr_o,
  input  logic [DATA_W-1:0]       salida_i
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(POLL_GAP + 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt, sel, sel_nxt;
  logic [LEN_W-1:0]   len_q, len_nxt, idx, idx_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [N_REQ-1:0]   ready_nxt, gnt_nxt, done_nxt;
  logic               busy_nxt, wr_nxt, reg_sel_nxt;
  logic [DATA_W-1:0]  entrada_nxt, addr_nxt;

  logic [N_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  logic [LEN_W-1:0]   lens  [N_REQ];
  logic [DATA_W-1:0]  words [N_REQ];

  // Only the send-in-progress flag of the readback is meaningful here.
  logic unused_salida;
  assign unused_salida = ^salida_i[DATA_W-1:1];

  for (genvar r = 0; r < N_REQ; r++) begin : g_unpack
    assign lens[r]  = len_i[LEN_W*r +: LEN_W];
    assign words[r] = word_i[DATA_W*r +: DATA_W];
  end

  uart_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req (req_i),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    sel_nxt     = sel;
    len_nxt     = len_q;
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    ready_nxt   = word_ready_o;
    gnt_nxt     = gnt_o;
    done_nxt    = '0;
    wr_nxt      = 1'b0;
    reg_sel_nxt = reg_sel_o;
    entrada_nxt = entrada_o;
    addr_nxt    = addr_o;
    case (state)
      IDLE: begin
        if (arb_any) begin
          state_nxt = LOAD;
          sel_nxt   = arb_idx;
          len_nxt   = lens[arb_idx];
          idx_nxt   = '0;
          gnt_nxt   = arb_gnt;
          ready_nxt = arb_gnt;
        end
      end
      LOAD: begin
        if (word_valid_i[sel] && word_ready_o[sel]) begin
          wr_nxt      = 1'b1;
          reg_sel_nxt = 1'b1;
          addr_nxt    = DATA_W'(idx);
          entrada_nxt = words[sel];
          idx_nxt     = idx + 1'b1;
          if (idx == len_q) begin
            ready_nxt = '0;
            state_nxt = CMD;
          end
        end
      end
      CMD: begin
        wr_nxt      = 1'b1;
        reg_sel_nxt = 1'b0;
        addr_nxt    = '0;
        entrada_nxt = ctrl_word(len_q);
        cnt_nxt     = '0;
        state_nxt   = POLL;
      end
      POLL: begin
        reg_sel_nxt = 1'b0;
        if (cnt == CNT_W'(POLL_GAP)) begin
          if (salida_i[0]) begin
            cnt_nxt = '0;
          end else begin
            done_nxt[sel] = 1'b1;
            state_nxt     = DONE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        gnt_nxt   = '0;
        ptr_nxt   = (sel == IDX_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State register plus registered outputs; reset leaves everything at zero.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= IDLE;
      ptr          <= '0;
      sel          <= '0;
      len_q        <= '0;
      idx          <= '0;
      cnt          <= '0;
      word_ready_o <= '0;
      gnt_o        <= '0;
      done_o       <= '0;
      busy_o       <= 1'b0;
      wr_o         <= 1'b0;
      reg_sel_o    <= 1'b0;
      entrada_o    <= '0;
      addr_o       <= '0;
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      sel          <= sel_nxt;
      len_q        <= len_nxt;
      idx          <= idx_nxt;
      cnt          <= cnt_nxt;
      word_ready_o <= ready_nxt;
      gnt_o        <= gnt_nxt;
      done_o       <= done_nxt;
      busy_o       <= busy_nxt;
      wr_o         <= wr_nxt;
      reg_sel_o    <= reg_sel_nxt;
      entrada_o    <= entrada_nxt;
      addr_o       <= addr_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_scheduler
// Brief    : Randomized bench for uart_tx_scheduler against a transaction-level
//            model of grant order, write sequence and status-poll timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

  localparam int N   = 2;
  localparam int GAP = 4;

  logic            clk = 1'b0;
  logic            reset_n_i;
  logic [N-1:0]    req_i;
  logic [N*8-1:0]  len_i;
  logic [N*32-1:0] word_i;
  logic [N-1:0]    word_valid_i;
  logic [N-1:0]    word_ready_o, gnt_o, done_o;
  logic            busy_o, wr_o, reg_sel_o;
  logic [31:0]     entrada_o, addr_o, salida_i;

  uart_tx_scheduler #(.N_REQ(N), .POLL_GAP(GAP)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n_i),
    .req_i        (req_i),
    .len_i        (len_i),
    .word_i       (word_i),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .gnt_o        (gnt_o),
    .done_o       (done_o),
    .busy_o       (busy_o),
    .wr_o         (wr_o),
    .reg_sel_o    (reg_sel_o),
    .entrada_o    (entrada_o),
    .addr_o       (addr_o),
    .salida_i     (salida_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  // Cycle number: value during cycle n is n.
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic        sel;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         wlog[$];
  int          acc_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] words [N][256];
  int          nbusy [N];
  int          valid_pct  = 100;
  int          busy_until = -1;
  int          exp_done   = 0;
  int          mptr = 0;
  int          rd_w = 0;
  int          rd_a = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  // Log every peripheral write with the cycle it was on the bus.
  always @(negedge clk) begin
    if (wr_o) wlog.push_back('{cyc, reg_sel_o, addr_o, entrada_o});
  end

  // Word sources: present the next word per requester, random valid.
  initial begin
    logic [N-1:0] pv, pr;
    int           pc;
    int           di [N];
    pv = '0; pr = '0; pc = 0;
    for (int r = 0; r < N; r++) di[r] = 0;
    word_valid_i = '0;
    word_i       = '0;
    forever begin
      @(negedge clk);
      for (int r = 0; r < N; r++) begin
        if (pv[r] && pr[r]) begin
          acc_q.push_back(pc);
          di[r]++;
        end
        if (!req_i[r]) di[r] = 0;
        word_valid_i[r]    = ($urandom_range(99) < valid_pct);
        word_i[32*r +: 32] = words[r][di[r] & 255];
      end
      pv = word_valid_i;
      pr = word_ready_o;
      pc = cyc;
    end
  end

  // Peripheral status: busy for nbusy samples taken on the spec poll schedule.
  initial begin
    logic [31:0] v;
    int          gi;
    salida_i = '0;
    forever begin
      @(negedge clk);
      if (wr_o && !reg_sel_o) begin
        gi = 0;
        for (int r = 0; r < N; r++) if (gnt_o[r]) gi = r;
        busy_until = cyc + GAP + nbusy[gi] * (GAP + 1) - 1;
        exp_done   = busy_until + 2;
      end
      v        = $urandom;
      v[0]     = (cyc <= busy_until);
      salida_i = v;
    end
  end

  task automatic finish_tb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic set_txn(input int r, input int len, input int b);
    len_i[8*r +: 8] = len[7:0];
    nbusy[r] = b;
    for (int i = 0; i < 256; i++) words[r][i] = $urandom;
  endtask

  task automatic check_txn(input int g);
    wr_t e;
    int  len;
    int  last;
    len  = int'(len_i[8*g +: 8]);
    last = 0;
    check("wr_count", wlog.size() - rd_w, len + 2);
    check("acc_count", acc_q.size() - rd_a, len + 1);
    for (int i = 0; i <= len; i++) begin
      if (rd_w < wlog.size()) begin
        e = wlog[rd_w];
        rd_w++;
        check("data_sel_addr", {e.sel, e.addr}, {1'b1, 32'(i)});
        check("data_word", e.data, words[g][i]);
        if (rd_a < acc_q.size()) begin
          check("data_time", e.c, acc_q[rd_a] + 1);
          rd_a++;
        end
        last = e.c;
      end
    end
    if (rd_w < wlog.size()) begin
      e = wlog[rd_w];
      rd_w++;
      check("ctrl_sel_addr", {e.sel, e.addr}, 33'd0);
      check("ctrl_data", e.data, 32'(len * 16 + 1));
      check("ctrl_time", e.c, last + 1);
    end
    rd_w = wlog.size();
    rd_a = acc_q.size();
  endtask

  task automatic run_batch(input logic [N-1:0] mask);
    logic [N-1:0] rem;
    int           g;
    bit           ok;
    @(negedge clk);
    req_i = mask;
    rem   = mask;
    @(negedge clk);
    g = pick(rem, mptr);
    check("grant_latency", {busy_o, gnt_o, word_ready_o}, {1'b1, oh(g), oh(g)});
    while (rem != 0) begin
      g  = pick(rem, mptr);
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        @(negedge clk);
        if (done_o != 0) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        check("done_timeout", done_o, oh(g));
        finish_tb();
      end
      check("done_pulse", done_o, oh(g));
      check("done_time", cyc, exp_done);
      check("gnt_in_done", {busy_o, gnt_o}, {1'b1, oh(g)});
      check_txn(g);
      req_i[g] = 1'b0;
      rem[g]   = 1'b0;
      mptr     = (g + 1) % N;
      @(negedge clk);
      check("after_done", {busy_o, gnt_o, done_o, word_ready_o}, '0);
      if (rem != 0) begin
        @(negedge clk);
        check("next_grant", gnt_o, oh(pick(rem, mptr)));
      end
    end
  endtask

  initial begin
    reset_n_i = 1'b0;
    req_i     = '0;
    len_i     = '0;
    for (int r = 0; r < N; r++) set_txn(r, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_ctl", {word_ready_o, gnt_o, done_o, busy_o, wr_o, reg_sel_o}, '0);
    check("rst_data", entrada_o, 32'd0);
    check("rst_addr", addr_o, 32'd0);

    // Both requesters waiting at reset release: 0 then 1.
    set_txn(0, $urandom_range(7), $urandom_range(3));
    set_txn(1, $urandom_range(7), $urandom_range(3));
    reset_n_i = 1'b1;
    run_batch(2'b11);

    // Directed three-word transfer, three busy polls.
    set_txn(0, 2, 3);
    words[0][0] = 32'hA;
    words[0][1] = 32'hB;
    words[0][2] = 32'hC;
    run_batch(2'b01);

    // Full 256-word transfer with valid always high.
    set_txn(1, 255, 1);
    run_batch(2'b10);

    // Toggling valid and a long stuck-busy status.
    valid_pct = 50;
    set_txn(0, 5, 20);
    run_batch(2'b01);

    // Random mixes.
    for (int it = 0; it < 8; it++) begin
      valid_pct = $urandom_range(100, 30);
      for (int r = 0; r < N; r++) set_txn(r, $urandom_range(15), $urandom_range(3));
      run_batch(N'($urandom_range(3, 1)));
    end

    // Get the pointer to 1 so its reset to 0 is observable.
    valid_pct = 100;
    if (mptr == 0) begin
      set_txn(0, 1, 0);
      run_batch(2'b01);
    end

    // Reset in the middle of a load.
    set_txn(1, 20, 0);
    @(negedge clk);
    req_i = 2'b10;
    for (int i = 0; i < 200; i++) begin
      if (acc_q.size() - rd_a >= 5) break;
      @(negedge clk);
    end
    check("load_progress", acc_q.size() - rd_a, 5);
    check("busy_before_rst", {busy_o, gnt_o}, {1'b1, 2'b10});
    #2 reset_n_i = 1'b0;
    #1;
    check("arst_ctl", {word_ready_o, gnt_o, done_o, busy_o, wr_o, reg_sel_o}, '0);
    check("arst_data", entrada_o, 32'd0);
    check("arst_addr", addr_o, 32'd0);
    @(negedge clk);
    req_i = '0;
    repeat (2) @(negedge clk);
    reset_n_i = 1'b1;
    mptr = 0;
    rd_w = wlog.size();
    rd_a = acc_q.size();
    set_txn(0, $urandom_range(7), 1);
    set_txn(1, $urandom_range(7), 1);
    run_batch(2'b11);

    finish_tb();
  end

endmodule
`default_nettype wire
